// File: rtl/enka_pkg.sv
// Shared opcode/ALU encodings and defaults for the enka execute core.
package enka_pkg;

  localparam logic [63:0] PC_RESET_DEFAULT = 64'h0;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_ADDI = 4'd1,
    OP_ADDS = 4'd2,
    OP_BLT  = 4'd3,
    OP_B    = 4'd4,
    OP_CBZ  = 4'd5,
    OP_LDUR = 4'd6,
    OP_LSL  = 4'd7,
    OP_LSR  = 4'd8,
    OP_MUL  = 4'd9,
    OP_STUR = 4'd10,
    OP_SUBS = 4'd11
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_PASS = 3'b000,
    ALU_ADD  = 3'b010,
    ALU_SUB  = 3'b011,
    ALU_AND  = 3'b100,
    ALU_OR   = 3'b101,
    ALU_XOR  = 3'b110
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/enka_alu.sv
// 64-bit ALU: pass/add/sub/logic ops with NZCV flag generation.
module enka_alu
  import enka_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result,
  output flags_t      flags
);

  logic [64:0] sum;
  logic        carry;
  logic        ovf;

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      ALU_PASS: result = b;
      ALU_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[63:0];
        carry  = sum[64];
        ovf    = (a[63] == b[63]) && (sum[63] != a[63]);
      end
      // Subtract as A + ~B + 1 so carry means "no borrow"
      ALU_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + 65'd1;
        result = sum[63:0];
        carry  = sum[64];
        ovf    = (a[63] != b[63]) && (sum[63] != a[63]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

  assign flags.n = result[63];
  assign flags.z = (result == 64'd0);
  assign flags.c = carry;
  assign flags.v = ovf;

endmodule

// File: rtl/enka_exec_core.sv
// Single-cycle decode/execute core: inline decoder and PC logic, ALU sub-module.
// Define ENKA_EXEC_TRACE_EN to print a per-cycle execution trace.
module enka_exec_core
  import enka_pkg::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [63:0] da,
  input  logic [63:0] db,
  output logic [4:0]  rn,
  output logic [4:0]  rm,
  output logic [4:0]  rd,
  output logic [4:0]  rb_sel,
  output logic [3:0]  opcode,
  output logic        reg2loc,
  output logic        reg_write,
  output logic        mem_write,
  output logic [1:0]  mem_to_reg,
  output logic [63:0] alu_result,
  output logic [5:0]  shamt,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_c,
  output logic [63:0] pc
);

  opcode_t     op;
  logic [2:0]  alu_op;
  logic [63:0] alu_b;
  flags_t      alu_flags;
  flags_t      flags_q;
  logic [63:0] pc_next;
  logic [63:0] br_off26;
  logic [63:0] br_off19;

  always_comb begin
    op = OP_NONE;
    if      (inst[31:22] == 10'b1001000100)                          op = OP_ADDI;
    else if (inst[31:21] == 11'b10101011000)                         op = OP_ADDS;
    else if (inst[31:24] == 8'b01010100 && inst[4:0] == 5'b01011)    op = OP_BLT;
    else if (inst[31:26] == 6'b000101)                               op = OP_B;
    else if (inst[31:24] == 8'b10110100)                             op = OP_CBZ;
    else if (inst[31:21] == 11'b11111000010)                         op = OP_LDUR;
    else if (inst[31:21] == 11'b11010011011)                         op = OP_LSL;
    else if (inst[31:21] == 11'b11010011010)                         op = OP_LSR;
    else if (inst[31:21] == 11'b10011011000)                         op = OP_MUL;
    else if (inst[31:21] == 11'b11111000000)                         op = OP_STUR;
    else if (inst[31:21] == 11'b11101011000)                         op = OP_SUBS;
  end

  assign opcode     = op;
  assign rn         = inst[9:5];
  assign rm         = inst[20:16];
  assign rd         = inst[4:0];
  assign shamt      = inst[15:10];
  assign reg2loc    = !(op == OP_STUR || op == OP_CBZ);
  assign rb_sel     = reg2loc ? rm : rd;
  assign reg_write  = !(op == OP_B || op == OP_BLT || op == OP_CBZ ||
                        op == OP_STUR || op == OP_NONE);
  assign mem_write  = (op == OP_STUR);

  always_comb begin
    mem_to_reg = 2'd0;
    case (op)
      OP_LDUR:        mem_to_reg = 2'd1;
      OP_MUL:         mem_to_reg = 2'd2;
      OP_LSL, OP_LSR: mem_to_reg = 2'd3;
      default:        mem_to_reg = 2'd0;
    endcase
  end

  always_comb begin
    alu_b = db;
    if (op == OP_ADDI)                        alu_b = {52'd0, inst[21:10]};
    else if (op == OP_LDUR || op == OP_STUR)  alu_b = {{55{inst[20]}}, inst[20:12]};
  end

  always_comb begin
    alu_op = ALU_ADD;
    if (op == OP_SUBS)     alu_op = ALU_SUB;
    else if (op == OP_CBZ) alu_op = ALU_PASS;
  end

  enka_alu u_alu (
    .op     (alu_op),
    .a      (da),
    .b      (alu_b),
    .result (alu_result),
    .flags  (alu_flags)
  );

  assign br_off26 = {{36{inst[25]}}, inst[25:0], 2'b00};
  assign br_off19 = {{43{inst[23]}}, inst[23:5], 2'b00};

  // B.LT looks at the registered flags; CBZ at this cycle's zero result
  always_comb begin
    pc_next = pc + 64'd4;
    if (op == OP_B)                                   pc_next = pc + br_off26;
    else if (op == OP_BLT && (flags_q.n ^ flags_q.v)) pc_next = pc + br_off19;
    else if (op == OP_CBZ && alu_flags.z)             pc_next = pc + br_off19;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= PC_RESET;
      flags_q <= '0;
    end else begin
      pc <= pc_next;
      if (op == OP_ADDS || op == OP_SUBS) flags_q <= alu_flags;
    end
  end

  assign flag_n = flags_q.n;
  assign flag_z = flags_q.z;
  assign flag_c = flags_q.c;
  assign flag_v = flags_q.v;

`ifdef ENKA_EXEC_TRACE_EN
  always_ff @(posedge clk) begin
    $display("enka op=%0d pc=%h pc_next=%h alu=%h nzcv=%b%b%b%b",
             opcode, pc, pc_next, alu_result, flag_n, flag_z, flag_c, flag_v);
  end
`else
  // no trace output
`endif

endmodule

// File: tb/tb_enka_exec_core.sv
// Directed bench for enka_exec_core: reference model compared every cycle plus literal pins.
module tb_enka_exec_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [63:0] da, db;
  logic [4:0]  rn, rm, rd, rb_sel;
  logic [3:0]  opcode;
  logic        reg2loc, reg_write, mem_write;
  logic [1:0]  mem_to_reg;
  logic [63:0] alu_result, pc;
  logic [5:0]  shamt;
  logic        flag_n, flag_z, flag_v, flag_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enka_exec_core #(.PC_RESET(64'h0)) dut (
    .clk(clk), .rst(rst), .inst(inst), .da(da), .db(db),
    .rn(rn), .rm(rm), .rd(rd), .rb_sel(rb_sel), .opcode(opcode),
    .reg2loc(reg2loc), .reg_write(reg_write), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .alu_result(alu_result), .shamt(shamt),
    .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c),
    .pc(pc)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: table-driven decode, plain arithmetic for results
  typedef struct {
    logic [3:0]  opc;
    logic        r2l, rw, mw;
    logic [1:0]  m2r;
    logic [4:0]  rb;
    logic [63:0] res;
    logic        n, z, c, v;
    logic [63:0] pcn;
  } exp_t;

  localparam logic [31:0] MASK  [11] = '{32'hFFC00000, 32'hFFE00000, 32'hFF00001F,
    32'hFC000000, 32'hFF000000, 32'hFFE00000, 32'hFFE00000, 32'hFFE00000,
    32'hFFE00000, 32'hFFE00000, 32'hFFE00000};
  localparam logic [31:0] MATCH [11] = '{32'h91000000, 32'hAB000000, 32'h5400000B,
    32'h14000000, 32'hB4000000, 32'hF8400000, 32'hD3600000, 32'hD3400000,
    32'h9B000000, 32'hF8000000, 32'hEB000000};

  function automatic exp_t model(input logic [31:0] i, input logic [63:0] a, input logic [63:0] bb,
                                 input logic [63:0] cur_pc, input logic fn, input logic fv);
    exp_t e;
    logic [63:0] b;
    logic signed [64:0] wide;
    logic [64:0] usum;
    longint off;
    e.opc = 4'd0;
    for (int k = 0; k < 11; k++)
      if (e.opc == 4'd0 && (i & MASK[k]) == MATCH[k]) e.opc = 4'(k + 1);
    e.r2l = !(e.opc == 10 || e.opc == 5);
    e.rw  = !(e.opc inside {4'd0, 4'd3, 4'd4, 4'd5, 4'd10});
    e.mw  = (e.opc == 10);
    e.m2r = (e.opc == 6) ? 2'd1 : (e.opc == 9) ? 2'd2 : (e.opc == 7 || e.opc == 8) ? 2'd3 : 2'd0;
    e.rb  = e.r2l ? i[20:16] : i[4:0];
    b = bb;
    if (e.opc == 1) b = 64'(i[21:10]);
    if (e.opc == 6 || e.opc == 10) b = 64'(longint'($signed(i[20:12])));
    e.c = 1'b0; e.v = 1'b0;
    if (e.opc == 5) e.res = b;
    else if (e.opc == 11) begin
      e.res = a - b;
      e.c   = (a >= b);
      wide  = $signed({a[63], a}) - $signed({b[63], b});
      e.v   = wide[64] ^ wide[63];
    end else begin
      e.res = a + b;
      usum  = {1'b0, a} + {1'b0, b};
      e.c   = usum[64];
      wide  = $signed({a[63], a}) + $signed({b[63], b});
      e.v   = wide[64] ^ wide[63];
    end
    e.n = e.res[63];
    e.z = (e.res == 64'd0);
    e.pcn = cur_pc + 64'd4;
    if (e.opc == 4) begin
      off = longint'($signed(i[25:0])) * 4;
      e.pcn = cur_pc + 64'(off);
    end else if ((e.opc == 3 && (fn ^ fv)) || (e.opc == 5 && e.z)) begin
      off = longint'($signed(i[23:5])) * 4;
      e.pcn = cur_pc + 64'(off);
    end
    return e;
  endfunction

  logic [63:0] m_pc = '0;
  logic        m_n = 0, m_z = 0, m_c = 0, m_v = 0;
  logic        m_valid = 0;

  always @(posedge clk) begin
    exp_t e;
    e = model(inst, da, db, m_pc, m_n, m_v);
    m_valid <= 1'b1;
    if (rst) begin
      m_pc <= 64'h0;
      {m_n, m_z, m_c, m_v} <= 4'b0000;
    end else begin
      m_pc <= e.pcn;
      if (e.opc == 2 || e.opc == 11) {m_n, m_z, m_c, m_v} <= {e.n, e.z, e.c, e.v};
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (m_valid) begin
      e = model(inst, da, db, m_pc, m_n, m_v);
      chk("opcode", 64'(opcode), 64'(e.opc));
      chk("decode", {52'd0, reg2loc, reg_write, mem_write, mem_to_reg, rb_sel, rn[0]},
          {52'd0, e.r2l, e.rw, e.mw, e.m2r, e.rb, inst[5]});
      chk("fields", {49'd0, rn, rm, rd}, {49'd0, inst[9:5], inst[20:16], inst[4:0]});
      chk("shamt", 64'(shamt), 64'(inst[15:10]));
      chk("alu_result", alu_result, e.res);
      chk("pc", pc, m_pc);
      chk("flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, {60'd0, m_n, m_z, m_c, m_v});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
    inst = i; da = a; db = b;
    #1;
  endtask

  initial begin
    rst = 1'b1; inst = '0; da = '0; db = '0;
    step();
    chk("reset_pc", pc, 64'h0);
    chk("reset_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'h0);
    rst = 1'b0;
    step();
    chk("release_pc", pc, 64'h4);

    set(32'h91001401, 64'd10, 64'd0);
    chk("addi_opcode", 64'(opcode), 64'd1);
    chk("addi_rd", 64'(rd), 64'd1);
    chk("addi_result", alu_result, 64'd15);
    chk("addi_rw", 64'(reg_write), 64'd1);
    step();
    chk("addi_flags_hold", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'h0);
    chk("addi_pc", pc, 64'h8);

    set(32'hEB000000, 64'd3, 64'd5);
    chk("subs_result", alu_result, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    chk("subs_flags_nzcv", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'b1000);
    set(32'h5400008B, 64'd0, 64'd0);
    step();
    chk("blt_taken_pc", pc, 64'h1C);

    // reset must win over a flag-setting instruction
    rst = 1'b1;
    set(32'hEB000000, 64'd3, 64'd5);
    step();
    chk("rst_dominates_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'h0);
    rst = 1'b0;
    set(32'h14000010, 64'd0, 64'd0);
    step();
    chk("b_to_40", pc, 64'h40);
    set(32'hB4FFFFC0, 64'd0, 64'd0);
    chk("cbz_rw", 64'(reg_write), 64'd0);
    step();
    chk("cbz_taken_pc", pc, 64'h38);
    set(32'h14000002, 64'd0, 64'd0);
    step();
    set(32'hB4FFFFC0, 64'd0, 64'd1);
    step();
    chk("cbz_not_taken_pc", pc, 64'h44);

    rst = 1'b1; set(32'h0, 64'd0, 64'd0); step(); rst = 1'b0;
    set(32'h14000004, 64'd0, 64'd0);
    step();
    set(32'h17FFFFFF, 64'd0, 64'd0);
    step();
    chk("b_back_pc", pc, 64'h0C);
    set(32'hF85F8000, 64'h100, 64'd0);
    chk("ldur_result", alu_result, 64'hF8);
    chk("ldur_m2r", 64'(mem_to_reg), 64'd1);
    step();

    set(32'hAB000000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    step();
    chk("adds_ovf_nzcv", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'b1001);
    set(32'hAB000000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    step();
    chk("adds_wrap_nzcv", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'b0110);
    chk("pc_before_blt", pc, 64'h18);
    set(32'h5400008B, 64'd0, 64'd0);
    step();
    chk("blt_not_taken_pc", pc, 64'h1C);

    set(32'hF81F8123, 64'h200, 64'd7);
    chk("stur_mw", {62'd0, mem_write, reg2loc}, 64'b10);
    chk("stur_rb_sel", 64'(rb_sel), 64'd3);
    step();
    set(32'h9B0A7C41, 64'd6, 64'd9);
    chk("mul_m2r", 64'(mem_to_reg), 64'd2);
    step();
    set(32'hD3600C41, 64'd1, 64'd2);
    chk("lsl_opcode", 64'(opcode), 64'd7);
    step();
    set(32'hD3400C41, 64'd1, 64'd2);
    step();
    set(32'hAB1F03E0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    step();
    set(32'hEB010000, 64'd5, 64'd5);
    step();
    set(32'h00000000, 64'd1, 64'd2);
    chk("unknown_rw", {62'd0, reg_write, 1'b0}, 64'd0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
